// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg: shared types and constants for the ACE snoop responder.
package ace_snoop_pkg;
  typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_e;
  typedef enum logic [3:0] {
    SNP_READ_ONCE     = 4'b0000,
    SNP_READ_SHARED   = 4'b0001,
    SNP_READ_CLEAN    = 4'b0010,
    SNP_READ_NSD      = 4'b0011,
    SNP_READ_UNIQUE   = 4'b0111,
    SNP_CLEAN_SHARED  = 4'b1000,
    SNP_CLEAN_INVALID = 4'b1001,
    SNP_MAKE_INVALID  = 4'b1101
  } ac_snoop_e;
  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;
  typedef enum logic [2:0] {IDLE, GRANT, LOOKUP, RESP, DATA, UPDATE} snp_fsm_e;
endpackage

// File: rtl/ace_snoop_responder_if.sv
// ace_snoop_responder_if: AC/CR/CD snoop channels plus the cache-array access port.
interface ace_snoop_responder_if #(parameter int WIDTH_A = 32, parameter int WIDTH_D = 32, parameter int LINE_WORDS = 4);
  logic                          AC_VALID;
  logic [3:0]                    AC_SNOOP;
  logic [2:0]                    AC_PROT;
  logic [WIDTH_A-1:0]            AC_ADDR;
  logic                          AC_READY;
  logic                          CR_READY;
  logic                          CR_VALID;
  logic [4:0]                    CR_RESP;
  logic                          CD_READY;
  logic                          CD_VALID;
  logic                          CD_LAST;
  logic [WIDTH_D-1:0]            CD_DATA;
  logic                          snp_req;
  logic                          snp_gnt;
  logic [WIDTH_A-1:0]            snp_addr;
  logic                          snp_hit;
  logic [1:0]                    snp_state;
  logic                          snp_rd_en;
  logic [$clog2(LINE_WORDS)-1:0] snp_word;
  logic [WIDTH_D-1:0]            snp_rdata;
  logic                          snp_upd;
  logic [1:0]                    snp_new_state;
  modport slave (
    input  AC_VALID, AC_SNOOP, AC_PROT, AC_ADDR, CR_READY, CD_READY, snp_gnt, snp_hit, snp_state, snp_rdata,
    output AC_READY, CR_VALID, CR_RESP, CD_VALID, CD_LAST, CD_DATA, snp_req, snp_addr, snp_rd_en, snp_word,
           snp_upd, snp_new_state
  );
  modport master (
    output AC_VALID, AC_SNOOP, AC_PROT, AC_ADDR, CR_READY, CD_READY, snp_gnt, snp_hit, snp_state, snp_rdata,
    input  AC_READY, CR_VALID, CR_RESP, CD_VALID, CD_LAST, CD_DATA, snp_req, snp_addr, snp_rd_en, snp_word,
           snp_upd, snp_new_state
  );
endinterface

// File: rtl/ace_snoop_responder_decide.sv
// snoop_decide: opcode+hit+MESI state -> CR_RESP, data transfer, new state, update strobe.
// SNOOP_UNSUPP_ERR_EN: unsupported opcodes answer Error instead of a plain miss.
module snoop_decide
  import ace_snoop_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       hit_i,
  input  mesi_e      state_i,
  output logic [4:0] resp_o,
  output logic       dt_o,
  output mesi_e      new_state_o,
  output logic       upd_o
);
  logic h, u, d, sup;
  logic [4:0] r;
  mesi_e ns;
  assign h = hit_i && state_i != MESI_I;
  assign u = state_i inside {MESI_E, MESI_M};
  assign d = state_i == MESI_M;
  always_comb begin
    sup = 1'b1;
    r = '0;
    ns = state_i;
    case (op_i)
      SNP_READ_ONCE: r = {u, 1'b1, 1'b0, 1'b0, 1'b1};
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
        r = {u, 1'b1, d, 1'b0, 1'b1};
        ns = MESI_S;
      end
      SNP_READ_UNIQUE: begin
        r = {u, 1'b0, d, 1'b0, 1'b1};
        ns = MESI_I;
      end
      SNP_CLEAN_INVALID: begin
        r = {u, 1'b0, d, 1'b0, d};
        ns = MESI_I;
      end
      SNP_CLEAN_SHARED: begin
        r = {u, 1'b1, d, 1'b0, d};
        ns = MESI_S;
      end
      SNP_MAKE_INVALID: begin
        r = {u, 4'b0000};
        ns = MESI_I;
      end
      default: sup = 1'b0;
    endcase
  end
`ifdef SNOOP_UNSUPP_ERR_EN
  assign resp_o = !sup ? 5'b00010 : h ? r : '0;
`else
  assign resp_o = (sup && h) ? r : '0;
`endif
  assign dt_o        = resp_o[CR_DT];
  assign new_state_o = (sup && h) ? ns : state_i;
  assign upd_o       = sup && h && ns != state_i;
endmodule

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: services one ACE snoop at a time against the L1 data cache arrays.
module ace_snoop_responder
  import ace_snoop_pkg::*;
#(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_WORDS = 4
) (
  input logic clk,
  input logic rst,
  ace_snoop_responder_if.slave bus
);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int OFF = $clog2(LINE_WORDS * WIDTH_D / 8);
  localparam logic [WIDTH_A-1:0] LINE_MASK = ~WIDTH_A'((1 << OFF) - 1);
  snp_fsm_e           state_q;
  logic [3:0]         op_q;
  logic [WIDTH_A-1:0] addr_q;
  logic [4:0]         resp_q, resp_d;
  logic               dt_q, dt_d, upd_need_q, upd_d;
  mesi_e              ns_q, ns_d;
  logic               ac_ready_q, snp_req_q, cr_valid_q, rd_q, pend_q, cd_valid_q, cd_last_q, upd_q;
  logic [WW-1:0]      word_q;
  logic [WIDTH_D-1:0] cd_data_q;
  logic               rd_en;
  logic               unused_prot;
  snoop_decide u_decide (
    .op_i       (op_q),
    .hit_i      (bus.snp_hit),
    .state_i    (mesi_e'(bus.snp_state)),
    .resp_o     (resp_d),
    .dt_o       (dt_d),
    .new_state_o(ns_d),
    .upd_o      (upd_d)
  );
  // next word is read either to start the line or in the handshake cycle of the previous beat
  assign rd_en = state_q == DATA && (rd_q || (cd_valid_q && bus.CD_READY && !cd_last_q));
  assign unused_prot        = ^bus.AC_PROT;
  assign bus.AC_READY       = ac_ready_q;
  assign bus.CR_VALID       = cr_valid_q;
  assign bus.CR_RESP        = resp_q;
  assign bus.CD_VALID       = cd_valid_q;
  assign bus.CD_LAST        = cd_last_q;
  assign bus.CD_DATA        = cd_data_q;
  assign bus.snp_req        = snp_req_q;
  assign bus.snp_addr       = addr_q;
  assign bus.snp_rd_en      = rd_en;
  assign bus.snp_word       = word_q;
  assign bus.snp_upd        = upd_q;
  assign bus.snp_new_state  = ns_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      resp_q     <= '0;
      dt_q       <= 1'b0;
      upd_need_q <= 1'b0;
      ns_q       <= MESI_I;
      ac_ready_q <= 1'b0;
      snp_req_q  <= 1'b0;
      cr_valid_q <= 1'b0;
      rd_q       <= 1'b0;
      pend_q     <= 1'b0;
      cd_valid_q <= 1'b0;
      cd_last_q  <= 1'b0;
      upd_q      <= 1'b0;
      word_q     <= '0;
      cd_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ac_ready_q <= !(bus.AC_VALID && ac_ready_q);
          if (bus.AC_VALID && ac_ready_q) begin
            op_q      <= bus.AC_SNOOP;
            addr_q    <= bus.AC_ADDR & LINE_MASK;
            snp_req_q <= 1'b1;
            state_q   <= GRANT;
          end
        end
        GRANT: state_q <= bus.snp_gnt ? LOOKUP : GRANT;
        LOOKUP: begin
          resp_q     <= resp_d;
          dt_q       <= dt_d;
          upd_need_q <= upd_d;
          ns_q       <= ns_d;
          cr_valid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: if (bus.CR_READY) begin
          cr_valid_q <= 1'b0;
          rd_q       <= dt_q;
          word_q     <= '0;
          upd_q      <= !dt_q && upd_need_q;
          state_q    <= dt_q ? DATA : UPDATE;
        end
        DATA: begin
          rd_q   <= 1'b0;
          pend_q <= rd_en;
          if (rd_en) word_q <= word_q + WW'(1);
          if (pend_q) begin
            cd_data_q  <= bus.snp_rdata;
            cd_valid_q <= 1'b1;
            cd_last_q  <= word_q == '0;
          end else if (cd_valid_q && bus.CD_READY) begin
            cd_valid_q <= 1'b0;
            cd_last_q  <= 1'b0;
            upd_q      <= cd_last_q && upd_need_q;
            state_q    <= cd_last_q ? UPDATE : DATA;
          end
        end
        UPDATE: begin
          upd_q     <= 1'b0;
          snp_req_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed and randomized snoops checked against a rule-level reference model.
module tb_ace_snoop_responder;
  localparam int WA = 32, WD = 32, LW = 4;
  localparam int LINE_BYTES = LW * WD / 8;
`ifdef SNOOP_UNSUPP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [WD-1:0] mem [LW];

  ace_snoop_responder_if #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_WORDS(LW)) bus ();
  ace_snoop_responder #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_WORDS(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.AC_READY, bus.CR_VALID, bus.CR_RESP, bus.CD_VALID, bus.CD_LAST, bus.CD_DATA, bus.snp_req,
             bus.snp_addr, bus.snp_rd_en, bus.snp_word, bus.snp_upd, bus.snp_new_state};
  endfunction

  // Returns {upd, new_state[1:0], data_transfer, cr_resp[4:0]} from the snoop rules.
  function automatic logic [8:0] ref_snoop(input logic [3:0] op, input logic hit, input logic [1:0] st);
    bit known = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    bit live = hit && st != 2'd0;
    bit uniq = st >= 2'd2;
    bit dirty = st == 2'd3;
    bit dt = 1'b0;
    logic [4:0] resp = '0;
    logic [1:0] ns = st;
    if (!known) resp = ERR_EN ? 5'b00010 : 5'b00000;
    else if (live) begin
      dt = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) || ((op inside {4'd8, 4'd9}) && dirty);
      ns = (op == 4'd0) ? st : (op inside {4'd1, 4'd2, 4'd3, 4'd8}) ? 2'b01 : 2'b00;
      resp = {uniq, op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8}, dirty && !(op inside {4'd0, 4'd13}), 1'b0, dt};
    end
    return {live && known && ns != st, ns, dt, resp};
  endfunction

  initial begin : rdata_model
    logic re;
    logic [1:0] w;
    bus.snp_rdata = '0;
    forever begin
      @(negedge clk);
      re = bus.snp_rd_en;
      w = bus.snp_word;
      @(posedge clk);
      #1;
      if (re) bus.snp_rdata = mem[w];
    end
  end

  task automatic wait_accept(input logic [3:0] op, input logic [WA-1:0] addr);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    bus.AC_VALID = 1'b1;
    bus.AC_SNOOP = op;
    bus.AC_ADDR = addr;
    bus.AC_PROT = 3'($urandom);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.AC_READY) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("ac_accept", ok, 1'b1);
  endtask

  // crm: 0 CR_READY high, 1 random. cdm: 0 CD_READY high, 1 random, 2 low for 5 cycles once data starts.
  task automatic snoop(input logic [3:0] op, input logic [WA-1:0] addr, input logic hit, input logic [1:0] st,
                       input int gd, input int crm, input int cdm);
    logic [8:0] e;
    int beats = 0, upds = 0, data_cyc = 0;
    bit saw_req = 1'b0, done = 1'b0, cr_seen = 1'b0, first_cr = 1'b0, stalled = 1'b0;
    logic [WD-1:0] pdata = '0;
    logic plast = 1'b0;
    e = ref_snoop(op, hit, st);
    for (int w = 0; w < LW; w++) mem[w] = $urandom;
    bus.snp_hit = hit;
    bus.snp_state = st;
    wait_accept(op, addr);
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      @(posedge clk);
      #1;
      bus.AC_VALID = 1'b0;
      bus.snp_gnt = cyc > gd;
      bus.CR_READY = crm == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      bus.CD_READY = cdm == 0 ? 1'b1 : cdm == 1 ? 1'($urandom_range(0, 1)) : data_cyc >= 5;
      @(negedge clk);
      if (cyc <= gd) check("gnt_wait", {bus.AC_READY, bus.CR_VALID}, 2'b00);
      check("cr_cd_excl", bus.CR_VALID && bus.CD_VALID, 1'b0);
      if (bus.CR_VALID && !first_cr) begin
        first_cr = 1'b1;
        if (gd == 0) check("cr_latency", cyc, 3);
      end
      if (bus.CR_VALID && bus.CR_READY) begin
        cr_seen = 1'b1;
        check("cr_resp", bus.CR_RESP, e[4:0]);
      end
      if (bus.CD_VALID || data_cyc > 0) data_cyc++;
      if (bus.CD_VALID) begin
        if (stalled) check("cd_stable", {bus.CD_LAST, bus.CD_DATA}, {plast, pdata});
        stalled = !bus.CD_READY;
        pdata = bus.CD_DATA;
        plast = bus.CD_LAST;
        if (bus.CD_READY) begin
          check("cd_data", bus.CD_DATA, beats < LW ? mem[beats] : '0);
          check("cd_last", bus.CD_LAST, beats == LW - 1);
          beats++;
        end
      end
      if (bus.snp_upd) begin
        upds++;
        check("new_state", bus.snp_new_state, e[7:6]);
      end
      if (bus.snp_req) begin
        saw_req = 1'b1;
        check("snp_addr", bus.snp_addr, addr & ~WA'(LINE_BYTES - 1));
      end else if (saw_req) begin
        done = 1'b1;
        check("ac_b2b", bus.AC_READY, 1'b0);
      end
    end
    bus.snp_gnt = 1'b0;
    check("snoop_done", done, 1'b1);
    check("cr_seen", cr_seen, 1'b1);
    check("beats", beats, e[5] ? LW : 0);
    check("upd_count", upds, e[8]);
  endtask

  task automatic rst_mid_data();
    int beats = 0;
    bit at_beat2 = 1'b0;
    for (int w = 0; w < LW; w++) mem[w] = $urandom;
    bus.snp_hit = 1'b1;
    bus.snp_state = 2'b11;
    bus.snp_gnt = 1'b1;
    bus.CR_READY = 1'b1;
    bus.CD_READY = 1'b1;
    wait_accept(4'b0001, 32'h0000_2000);
    for (int c = 0; c < 100 && !at_beat2; c++) begin
      @(posedge clk);
      #1;
      bus.AC_VALID = 1'b0;
      @(negedge clk);
      if (bus.CD_VALID && beats == 2) at_beat2 = 1'b1;
      else if (bus.CD_VALID && bus.CD_READY) beats++;
    end
    check("rst_reach_beat2", at_beat2, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_async_outs", any_out(), 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_outs", any_out(), 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.snp_gnt = 1'b0;
    @(negedge clk);
    check("rst_no_upd", {bus.snp_upd, bus.CD_VALID, bus.snp_req}, 3'b000);
    @(negedge clk);
    check("rst_ac_ready", bus.AC_READY, 1'b1);
    check("rst_no_beat", bus.CD_VALID, 1'b0);
  endtask

  initial begin : main
    logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    bus.AC_VALID = 1'b0;
    bus.AC_SNOOP = '0;
    bus.AC_PROT = '0;
    bus.AC_ADDR = '0;
    bus.CR_READY = 1'b0;
    bus.CD_READY = 1'b0;
    bus.snp_gnt = 1'b0;
    bus.snp_hit = 1'b0;
    bus.snp_state = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", any_out(), 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_ac_ready", bus.AC_READY, 1'b1);
    snoop(4'b0001, 32'h0000_1040, 1'b1, 2'b11, 0, 0, 0);
    snoop(4'b1101, 32'h0000_2084, 1'b1, 2'b10, 0, 0, 0);
    snoop(4'b0111, 32'h0000_3000, 1'b0, 2'b11, 0, 0, 0);
    snoop(4'b1000, 32'h0000_4010, 1'b1, 2'b01, 0, 0, 1);
    snoop(4'b0000, 32'h0000_5020, 1'b1, 2'b01, 0, 0, 2);
    snoop(4'b0001, 32'h0000_6030, 1'b1, 2'b10, 10, 0, 0);
    snoop(4'b1001, 32'h0000_7000, 1'b1, 2'b11, 0, 1, 1);
    rst_mid_data();
    snoop(4'b0101, 32'h0000_8000, 1'b1, 2'b11, 0, 0, 0);
    snoop(4'b0101, 32'h0000_8040, 1'b0, 2'b00, 0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 7)] : 4'($urandom);
      snoop(op, $urandom, 1'($urandom), 2'($urandom), $urandom_range(0, 3), 1, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Services ACE snoop transactions from the interconnect on behalf of the L1 data cache.
- Consumes the AC snoop address channel and produces the CR snoop response and CD snoop data channels that the cache top level exposes.
- Gains exclusive access to the cache arrays through a request/grant port, then:
  - looks up tag/state;
  - streams a full line for data-returning snoops;
  - writes back the new MESI state.
- Handles one snoop at a time; the interconnect sees backpressure on AC_READY.

Parameters:
- WIDTH_A, 32, address width.
- WIDTH_D, 32, data/beat width.
- LINE_WORDS, 4, words per cache line (power of 2, ≥2); equals CD beats per transfer.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- AC_VALID  in  1  snoop address valid
- AC_SNOOP  in  4  snoop opcode
- AC_PROT  in  3  protection (ignored, not stored)
- AC_ADDR  in  WIDTH_A  snoop address
- AC_READY  out  1  snoop address accept
- CR_READY  in  1  response accept
- CR_VALID  out  1  response valid
- CR_RESP  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- CD_READY  in  1  data accept
- CD_VALID  out  1  data beat valid
- CD_LAST  out  1  final beat
- CD_DATA  out  WIDTH_D  data beat
- snp_req  out  1  request cache-array ownership
- snp_gnt  in  1  ownership granted (level)
- snp_addr  out  WIDTH_A  line address (offset bits zero)
- snp_hit  in  1  tag hit, valid 1 cycle after grant
- snp_state  in  2  MESI state with hit: 00 I, 01 S, 10 E, 11 M
- snp_rd_en  out  1  data word read strobe
- snp_word  out  log2(LINE_WORDS)  word index
- snp_rdata  in  WIDTH_D  read data, 1 cycle after snp_rd_en
- snp_upd  out  1  one-cycle state write strobe
- snp_new_state  out  2  state to write

Behaviour:
- Reset (async, any state): FSM→IDLE. All outputs 0, except AC_READY=1 once the FSM sits in IDLE after reset deassertion. An in-flight snoop is abandoned: no update, no further beats.
- IDLE:
  - AC_READY=1.
  - On AC_VALID&AC_READY, latch opcode and line address (AC_ADDR with offset cleared), assert snp_req, go to GRANT.
- GRANT:
  - AC_READY=0; snp_req held.
  - When snp_gnt=1, go to LOOKUP.
  - snp_req stays high through UPDATE; the line is locked against the CPU for the whole snoop.
- LOOKUP: sample snp_hit/snp_state; compute CR_RESP, data_needed and new_state; go to RESP.
- Decision rules (h = hit and state≠I; U = E|M; D = M):
  - Miss/I: resp 0, no data, no update.
  - ReadOnce 0000: DT=1, IsShared=1, WasUnique=U; state unchanged.
  - ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=D, WasUnique=U; new S.
  - ReadUnique 0111: DT=1, PassDirty=D, WasUnique=U; new I.
  - CleanInvalid 1001: DT=D, PassDirty=D, WasUnique=U; new I.
  - CleanShared 1000: DT=D, PassDirty=D, IsShared=1, WasUnique=U; new S.
  - MakeInvalid 1101: WasUnique=U, no data; new I.
  - Any other opcode: see Optional Feature.
- RESP:
  - CR_VALID=1 with CR_RESP stable until CR_READY.
  - After the handshake: go to DATA if DT=1, else UPDATE.
- DATA:
  - Beats go out in word order 0..LINE_WORDS-1 (no wrapping).
  - Issue snp_rd_en for word i; the next cycle load snp_rdata into the CD_DATA register and raise CD_VALID.
  - CD_DATA and CD_LAST stay stable while CD_VALID&!CD_READY.
  - The read for word i+1 issues in the handshake cycle of beat i, giving 1 beat per 2 cycles minimum.
  - CD_LAST=1 only on word LINE_WORDS-1; its handshake goes to UPDATE.
- UPDATE:
  - snp_upd=1 for exactly one cycle, only if the new state differs from the old.
  - Next cycle: snp_req=0, return to IDLE.
  - Back-to-back snoops: AC accepted no earlier than the cycle after snp_req drops.
- Latency for a miss with grant and CR_READY held high: AC handshake → CR_VALID is 3 cycles.
- CR_VALID and CD_VALID are never simultaneously high.

Optional Feature:
- Macro SNOOP_UNSUPP_ERR_EN.
- Defined: unsupported opcodes return CR_RESP=00010 (Error) with no data and no update, whether hit or miss.
- Undefined: unsupported opcodes are treated as a miss: CR_RESP=0, no data, no update.

Decomposition:
- Package ace_snoop_pkg:
  - enum mesi_e (I,S,E,M);
  - enum ac_snoop_e (opcode constants);
  - CR_RESP bit-index localparams;
  - enum snp_fsm_e (IDLE,GRANT,LOOKUP,RESP,DATA,UPDATE).
- One sub-module, snoop_decide: purely combinational opcode+hit+state → {resp, data_needed, new_state, upd_needed}, reusable by the verification model.

Test Plan:
- ReadShared to 0x0000_1040, hit M, CR_READY/CD_READY high → CR_RESP=11101; 4 beats words 0..3, CD_LAST on beat 4; snp_upd with new state 01.
- MakeInvalid, hit E → CR_RESP=10000, no CD_VALID, snp_upd new state 00.
- ReadUnique, miss → CR_RESP=00000, no beats, no snp_upd; CR_VALID 3 cycles after the AC handshake.
- CleanShared, hit S, CD_READY toggling 0/1 after data starts → DT=0 so no beats; separately, ReadOnce hit S with CD_READY held 0 for 5 cycles → CD_DATA/CD_LAST stable, then word order 0..3 intact.
- snp_gnt held 0 for 10 cycles after AC accept → AC_READY=0 and CR_VALID=0 throughout; proceeds normally on grant.
- rst pulsed during DATA beat 2 → all outputs 0 immediately, no snp_upd; opcode 0101 after reset → CR_RESP=00010 with the macro defined, 00000 without.
